// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   state_t : IDLE (no beat held) / BUSY (beat held, out_valid=1)
//   ptr_inc : wrap-around increment of the round-robin pointer
package rr_mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Next search start after granting index p out of n requesters.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-search: first set bit of req starting at ptr,
// wrapping N-1 -> 0.
// Ports:
//   req    [N-1:0]     request vector
//   ptr    [SEL_W-1:0] highest-priority index
//   any                at least one request
//   winner [SEL_W-1:0] selected index (0 when !any)
//   gnt    [N-1:0]     one-hot of winner (0 when !any)
module rr_priority_pick #(
  parameter int SEL_W = 4
) (
  input  logic [(2**SEL_W)-1:0] req,
  input  logic [SEL_W-1:0]      ptr,
  output logic                  any,
  output logic [SEL_W-1:0]      winner,
  output logic [(2**SEL_W)-1:0] gnt
);

  localparam int N = 2**SEL_W;

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down to offset 0 so the nearest
  // requester (lowest offset from ptr) is the last write and wins.
  // SEL_W-bit addition wraps modulo N for free.
  always_comb begin
    any    = |req;
    winner = '0;
    gnt    = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one valid/ready output among N = 2**SEL_W
// requesters; the winner's payload is captured through an N:1 select.
// Optional feature: define RR_MUX_LOCK_EN to add a lock input that lets
// the current owner be regranted (burst) without advancing the pointer.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req       [N-1:0]    level requests, held until granted
//   in_data   [N*DW-1:0] payloads, requester i at [i*DATA_W +: DATA_W]
//   lock      [N-1:0]    (RR_MUX_LOCK_EN only) burst lock per requester
//   gnt       [N-1:0]    one-hot, high in the capture cycle
//   out_valid/out_ready  downstream handshake
//   out_data  [DW-1:0]   captured payload
//   out_sel   [SW-1:0]   owner index of out_data
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [(2**SEL_W)-1:0]        req,
  input  logic [(2**SEL_W)*DATA_W-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
  input  logic [(2**SEL_W)-1:0]        lock,
`endif
  output logic [(2**SEL_W)-1:0]        gnt,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [SEL_W-1:0]             out_sel,
  input  logic                         out_ready
);

  localparam int N = 2**SEL_W;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr;
  logic             any;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     rr_oh;
  logic             can_accept;
  logic             take;
  logic             regrant;
  logic [SEL_W-1:0] winner;
  logic [DATA_W-1:0] win_data;

  rr_priority_pick #(.SEL_W(SEL_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (rr_idx),
    .gnt    (rr_oh)
  );

  assign out_valid  = (state == BUSY);
  // A handshake frees the output register in the same cycle, so the next
  // winner can be captured without a bubble.
  assign can_accept = (state == IDLE) || (out_valid && out_ready);
  assign take       = can_accept && any;

`ifdef RR_MUX_LOCK_EN
  assign regrant = out_valid && lock[out_sel] && req[out_sel];
`else
  assign regrant = 1'b0;
`endif

  assign winner   = regrant ? out_sel : rr_idx;
  assign win_data = in_data[int'(winner)*DATA_W +: DATA_W];

  // rst_n gating keeps gnt low while reset is asserted even though
  // state is IDLE and requests may be present.
  always_comb begin
    gnt = '0;
    if (take && rst_n) begin
      gnt = rr_oh;
      if (regrant) begin
        gnt          = '0;
        gnt[out_sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (can_accept) state_n = any ? BUSY : IDLE;
  end

  // Capture registers; hold their last value when the output drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else if (take) begin
      out_data <= win_data;
      out_sel  <= winner;
      // A locked regrant keeps the saved pointer for when the lock drops.
      if (!regrant) ptr <= SEL_W'(ptr_inc(32'(winner), N));
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 8;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]      lock;
  logic [N-1:0]      gnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_vld;
  int m_data, m_sel, m_ptr;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit m_regrant();
`ifdef RR_MUX_LOCK_EN
    return m_vld && lock[m_sel] && req[m_sel];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_winner();
    return m_regrant() ? m_sel : rr_win(req, m_ptr);
  endfunction

  function automatic bit m_take();
    return (!m_vld || out_ready) && (req != '0);
  endfunction

  task automatic m_reset();
    m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 0;
  endtask

  // Inputs already driven (at negedge). Check gnt, clock, check outputs.
  task automatic step(input string tag);
    logic [N-1:0] eg;
    int w;
    bit rg;
    eg = '0;
    w  = m_winner();
    rg = m_regrant();
    if (m_take()) eg[w] = 1'b1;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    if (!m_vld || out_ready) begin
      if (req != '0) begin
        m_data = int'(in_data[w*DATA_W +: DATA_W]);
        m_sel  = w;
        if (!rg) m_ptr = (w + 1) % N;
        m_vld  = 1;
      end else begin
        m_vld = 0;
      end
    end
    #1;
    chk({tag, ".vld"},  32'(out_valid), 32'(m_vld));
    chk({tag, ".data"}, 32'(out_data),  32'(m_data));
    chk({tag, ".sel"},  32'(out_sel),   32'(m_sel));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '1; lock = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*DATA_W +: DATA_W] = 8'(i);
    m_reset();

    // reset with all requests high
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst.vld",  32'(out_valid), 0);
    chk("rst.sel",  32'(out_sel),   0);
    chk("rst.data", 32'(out_data),  0);
    chk("rst.gnt",  32'(gnt),       0);
    @(negedge clk);
    rst_n = 1'b1;

    // rotation 0..15,0 back to back
    for (int i = 0; i <= N; i++) begin
      step("rot");
      chk("rot.seq", 32'(out_sel), 32'(i % N));
      chk("rot.val", 32'(out_data), 32'(i % N));
    end

    // stall on requester 5
    in_data[5*DATA_W +: DATA_W] = 8'hA5;
    req = 16'h0020; out_ready = 1'b1;
    step("st.get");
    chk("st.sel", 32'(out_sel), 5);
    req = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step("st.hold");
      chk("st.data", 32'(out_data), 32'h A5);
    end
    out_ready = 1'b1;
    step("st.drain");
    chk("st.idle", 32'(out_valid), 0);

    // wrap-around
    req = 16'h8000; step("wr.a"); chk("wr.15", 32'(out_sel), 15);
    req = 16'h8001; step("wr.b"); chk("wr.0",  32'(out_sel), 0);
    req = 16'h8000; step("wr.c"); chk("wr.15b", 32'(out_sel), 15);

    // async reset mid-stall
    req = 16'h0080; out_ready = 1'b1; step("ar.get");
    chk("ar.sel7", 32'(out_sel), 7);
    req = '0; out_ready = 1'b0; step("ar.stall");
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar.vld",  32'(out_valid), 0);
    chk("ar.sel",  32'(out_sel),   0);
    chk("ar.gnt",  32'(gnt),       0);
    @(negedge clk);
    rst_n = 1'b1;
    req = '1; out_ready = 1'b1;
    step("ar.first");
    chk("ar.ptr0", 32'(out_sel), 0);

`ifdef RR_MUX_LOCK_EN
    do_reset();
    req = 16'h0006; lock = 16'h0002; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("lk.burst");
      chk("lk.sel1", 32'(out_sel), 1);
    end
    lock = '0;
    step("lk.rel");
    chk("lk.sel2", 32'(out_sel), 2);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req       = 16'($urandom) & 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
`ifdef RR_MUX_LOCK_EN
      lock      = 16'($urandom) & 16'($urandom);
`endif
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
